// File: rtl/pupil_search_ctrl_pkg.sv
// pupil_search_pkg: shared types and defaults for the pupil search scheduler.
package pupil_search_pkg;

  localparam int COORD_W_DEF = 13;
  localparam int SCORE_W_DEF = 32;

  typedef logic [SCORE_W_DEF-1:0] score_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_EVAL,
    S_NEXT,
    S_DONE
  } state_t;

endpackage

// File: rtl/pupil_search_ctrl_stepper.sv
// pupil_raster_stepper: latches the search window and walks the candidate
// position in raster order, STEP pixels per move on each axis.
module pupil_raster_stepper
  import pupil_search_pkg::*;
#(
  parameter int COORD_W = COORD_W_DEF,
  parameter int STEP    = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_load,
  input  logic               i_advance,
  input  logic [COORD_W-1:0] i_x0,
  input  logic [COORD_W-1:0] i_y0,
  input  logic [COORD_W-1:0] i_x1,
  input  logic [COORD_W-1:0] i_y1,
  output logic [COORD_W-1:0] o_cur_x,
  output logic [COORD_W-1:0] o_cur_y,
  output logic               o_last
);

  logic [COORD_W-1:0] r_x0;
  logic [COORD_W-1:0] r_x1;
  logic [COORD_W-1:0] r_y1;
  logic [COORD_W-1:0] r_cur_x;
  logic [COORD_W-1:0] r_cur_y;

  // One extra bit so a step past the top coordinate cannot wrap to 0.
  logic [COORD_W:0] w_step;
  logic [COORD_W:0] w_nx;
  logic [COORD_W:0] w_ny;
  logic             w_x_fits;
  logic             w_y_fits;

  assign w_step   = (COORD_W+1)'(STEP);
  assign w_nx     = {1'b0, r_cur_x} + w_step;
  assign w_ny     = {1'b0, r_cur_y} + w_step;
  assign w_x_fits = (w_nx <= {1'b0, r_x1});
  assign w_y_fits = (w_ny <= {1'b0, r_y1});
  assign o_last   = !w_x_fits && !w_y_fits;
  assign o_cur_x  = r_cur_x;
  assign o_cur_y  = r_cur_y;

  // Window latch on load; raster step on advance (row wrap returns X to X0).
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_x0    <= '0;
      r_x1    <= '0;
      r_y1    <= '0;
      r_cur_x <= '0;
      r_cur_y <= '0;
    end else if (i_load) begin
      r_x0    <= i_x0;
      r_x1    <= i_x1;
      r_y1    <= i_y1;
      r_cur_x <= i_x0;
      r_cur_y <= i_y0;
    end else if (i_advance) begin
      if (w_x_fits) begin
        r_cur_x <= w_nx[COORD_W-1:0];
      end else begin
        r_cur_x <= r_x0;
        if (w_y_fits) begin
          r_cur_y <= w_ny[COORD_W-1:0];
        end
      end
    end
  end

endmodule

// File: rtl/pupil_search_ctrl.sv
// pupil_search_ctrl: schedules one correlation per candidate position over a
// rectangular window and keeps the best-scoring position.
// Optional watchdog on the correlator wait: define CORR_TIMEOUT_EN.
module pupil_search_ctrl
  import pupil_search_pkg::*;
#(
  parameter int COORD_W     = COORD_W_DEF,
  parameter int SCORE_W     = SCORE_W_DEF,
  parameter int STEP        = 4,
  parameter int TIMEOUT_CYC = 400000
) (
  input  logic               iCLK,
  input  logic               iRST,
  input  logic               iStart,
  input  logic [COORD_W-1:0] iWinX0,
  input  logic [COORD_W-1:0] iWinY0,
  input  logic [COORD_W-1:0] iWinX1,
  input  logic [COORD_W-1:0] iWinY1,
  output logic               oCorrStart,
  output logic [COORD_W-1:0] oCorrX,
  output logic [COORD_W-1:0] oCorrY,
  input  logic               iCorrDone,
  input  logic [SCORE_W-1:0] iCorrScore,
  output logic               oBusy,
  output logic               oDone,
  output logic               oValid,
  output logic [COORD_W-1:0] oBestX,
  output logic [COORD_W-1:0] oBestY,
  output logic [SCORE_W-1:0] oBestScore,
  output logic               oErr
);

  state_t             r_state;
  logic               r_corr_start;
  logic               r_busy;
  logic               r_done;
  logic               r_valid;
  logic [COORD_W-1:0] r_best_x;
  logic [COORD_W-1:0] r_best_y;
  logic [SCORE_W-1:0] r_best_score;
  logic [SCORE_W-1:0] r_score;

  logic               w_load;
  logic               w_advance;
  logic               w_last;
  logic               w_empty;
  logic [COORD_W-1:0] w_cur_x;
  logic [COORD_W-1:0] w_cur_y;

`ifdef CORR_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);
  logic [WD_W-1:0] r_wd_cnt;
  logic            r_err;
  assign oErr = r_err;
`else
  // No watchdog: the limit parameter remains only for interface uniformity.
  assign oErr = (TIMEOUT_CYC < 0);
`endif

  assign w_load    = (r_state == S_IDLE) && iStart;
  assign w_advance = (r_state == S_NEXT) && !w_last;
  assign w_empty   = (iWinX1 < iWinX0) || (iWinY1 < iWinY0);

  pupil_raster_stepper #(
    .COORD_W (COORD_W),
    .STEP    (STEP)
  ) u_stepper (
    .i_clk     (iCLK),
    .i_rst     (iRST),
    .i_load    (w_load),
    .i_advance (w_advance),
    .i_x0      (iWinX0),
    .i_y0      (iWinY0),
    .i_x1      (iWinX1),
    .i_y1      (iWinY1),
    .o_cur_x   (w_cur_x),
    .o_cur_y   (w_cur_y),
    .o_last    (w_last)
  );

  assign oCorrStart = r_corr_start;
  assign oCorrX     = w_cur_x;
  assign oCorrY     = w_cur_y;
  assign oBusy      = r_busy;
  assign oDone      = r_done;
  assign oValid     = r_valid;
  assign oBestX     = r_best_x;
  assign oBestY     = r_best_y;
  assign oBestScore = r_best_score;

  // Search FSM with registered launch/busy/done/best outputs.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_state      <= S_IDLE;
      r_corr_start <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_valid      <= 1'b0;
      r_best_x     <= '0;
      r_best_y     <= '0;
      r_best_score <= '0;
      r_score      <= '0;
`ifdef CORR_TIMEOUT_EN
      r_wd_cnt     <= '0;
      r_err        <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (iStart) begin
            r_valid      <= 1'b0;
            r_best_x     <= '0;
            r_best_y     <= '0;
            r_best_score <= '0;
`ifdef CORR_TIMEOUT_EN
            r_err        <= 1'b0;
`endif
            if (w_empty) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state      <= S_LAUNCH;
              r_corr_start <= 1'b1;
              r_busy       <= 1'b1;
            end
          end
        end
        S_LAUNCH: begin
          r_corr_start <= 1'b0;
          r_state      <= S_WAIT;
`ifdef CORR_TIMEOUT_EN
          r_wd_cnt     <= '0;
`endif
        end
        S_WAIT: begin
          if (iCorrDone) begin
            r_score <= iCorrScore;
            r_state <= S_EVAL;
          end
`ifdef CORR_TIMEOUT_EN
          else if (r_wd_cnt == WD_LAST) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_err   <= 1'b1;
          end else begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
          end
`endif
        end
        S_EVAL: begin
          if (!r_valid || (r_score > r_best_score)) begin
            r_best_x     <= w_cur_x;
            r_best_y     <= w_cur_y;
            r_best_score <= r_score;
          end
          r_valid <= 1'b1;
          r_state <= S_NEXT;
        end
        S_NEXT: begin
          if (w_last) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_state      <= S_LAUNCH;
            r_corr_start <= 1'b1;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
